mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Sequencing controller for the pipeline's multiply/divide resource (HI/LO).
- Accepts a one-cycle start from the E stage and models the fixed multi-cycle latency of mult/div.
- Raises `busy` so the stall unit freezes D while MDU instructions are pending, then commits the results to HI/LO.
- Serves mfhi/mflo reads combinationally. Serves mthi/mtlo as single-edge writes.

Parameters:
- MUL_LAT, 5: busy cycles for mult/multu (legal range 1..15).
- DIV_LAT, 10: busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; op/a/b are valid in the same cycle.
- op  in  4  operation code (values in the package).
- a  in  32  rs operand (forwarded value).
- b  in  32  rt operand (forwarded value).
- busy  out  1  registered; high while a mult/div is in flight.
- hi_out  out  32  current HI register; drives mfhi.
- lo_out  out  32  current LO register; drives mflo.

Behaviour:
- Reset (async, on reset high): state=IDLE, cnt=0, busy=0, HI=0, LO=0, pending regs=0. Reset mid-operation aborts the operation; no commit occurs.
- States: IDLE, RUN. 4-bit down-counter `cnt`.
- IDLE with start and op in {MULT, MULTU, DIV, DIVU}, except DIV/DIVU with b==0:
  - Latch the result into pend_hi/pend_lo.
  - cnt = MUL_LAT or DIV_LAT; go to RUN.
  - busy=1 from the next cycle.
- Arithmetic:
  - MULT: signed 32x32→64; HI = upper word, LO = lower word.
  - MULTU: the same, unsigned.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
- Divide by zero: no state change, busy stays 0, HI/LO unchanged.
- MTHI/MTLO with start: HI (resp. LO) = a at that edge; busy is not raised; visible on hi_out/lo_out in the next cycle.
- RUN:
  - cnt decrements each edge.
  - At the edge where cnt==1: HI=pend_hi, LO=pend_lo, busy=0, return to IDLE.
  - Latency: start sampled at edge t0; busy high for exactly LAT cycles; the new HI/LO are visible in the first cycle with busy=0.
- start while in RUN is ignored entirely; the stall unit guarantees it does not occur, and the bench asserts this.
- op MDU_NONE or an undefined code with start: no effect.
- hi_out/lo_out always show the committed registers, never pend values. mfhi issued while busy is the stall unit's responsibility.

Optional Feature:
- Macro MDU_CANCEL_EN.
- When defined: adds input port `cancel` (1 bit), used for exception/interrupt flush.
  - cancel in RUN: at the next edge go to IDLE, busy=0, cnt=0, no commit; HI/LO keep their pre-op values.
  - cancel in IDLE blocks a same-cycle start; mthi/mtlo are not applied either.
  - cancel coinciding with the commit edge (cnt==1) takes precedence, so no commit.
- When undefined: the port is absent and every started op always completes.

Decomposition:
- Package mdu_defs holds:
  - Op codes: MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6.
  - State encodings: IDLE=0, RUN=1.
  - Default latencies.
- Sub-module mdu_arith: purely combinational; op, a, b → res_hi, res_lo, div_zero. It keeps the signed/unsigned arithmetic separate from the sequencing FSM.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 → busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; HI/LO unchanged during busy.
- DIV a=0xFFFFFFF9 (-7), b=2 → busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 → busy never rises, HI/LO unchanged.
- MTHI a=0x12345678 then next-cycle MTLO a=0x9ABCDEF0 → hi_out/lo_out update one cycle after each; busy stays 0 throughout.
- Start DIV, assert reset at busy cycle 4 → busy=0, HI=LO=0 immediately; after release, no late commit.
- With MDU_CANCEL_EN: MULT 3*4, cancel at busy cycle 5 (commit edge) → busy=0, HI/LO keep their old values. A new MULT in the following cycle completes normally: LO=12.

Source files
------------

// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// default latencies.
package mdu_defs;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
// Signed division runs on magnitudes and fixes signs afterwards, so the
// -2^31 / -1 corner wraps cleanly instead of relying on signed '/' overflow.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, dvsr, q_u, r_u;
  logic        neg_a, neg_b;

  // Products, magnitude divide and result selection by op
  always_comb begin
    prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u   = {32'b0, a} * {32'b0, b};
    neg_a    = (op == MDU_DIV) & a[31];
    neg_b    = (op == MDU_DIV) & b[31];
    mag_a    = neg_a ? (~a + 32'd1) : a;
    mag_b    = neg_b ? (~b + 32'd1) : b;
    dvsr     = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_u      = mag_a / dvsr;
    r_u      = mag_a % dvsr;
    div_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        res_lo = (neg_a ^ neg_b) ? (~q_u + 32'd1) : q_u;
        res_hi = neg_a ? (~r_u + 32'd1) : r_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller. Latches the result at start, holds
// busy for the op's fixed latency, then commits to HI/LO.
// Optional flush input `cancel` is enabled with `define MDU_CANCEL_EN.
module mdu_ctrl
  import mdu_defs::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] hi_r, hi_n, lo_r, lo_n;
  logic [31:0] pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic [31:0] res_hi, res_lo;
  logic        div_zero;
  logic        flush;

`ifdef MDU_CANCEL_EN
  assign flush = cancel;
`else
  assign flush = 1'b0;
`endif

  mdu_arith u_arith (
    .op       (op),
    .a        (a),
    .b        (b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  // Next-state: launch from IDLE, count down in RUN, commit on the last edge
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi_r;
    lo_n      = lo_r;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              pend_hi_n = res_hi;
              pend_lo_n = res_lo;
              cnt_n     = 4'(MUL_LAT);
              state_n   = RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              if (!div_zero) begin
                pend_hi_n = res_hi;
                pend_lo_n = res_lo;
                cnt_n     = 4'(DIV_LAT);
                state_n   = RUN;
              end
            end
            MDU_MTHI: hi_n = a;
            MDU_MTLO: lo_n = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          // flush wins over a coincident commit
          cnt_n   = 4'd0;
          state_n = IDLE;
        end else if (cnt == 4'd1) begin
          hi_n    = pend_hi;
          lo_n    = pend_lo;
          cnt_n   = 4'd0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      busy    <= (state_n == RUN);
      hi_r    <= hi_n;
      lo_r    <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
    end
  end

  assign hi_out = hi_r;
  assign lo_out = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected HI/LO and busy
// length per op; a negedge monitor pops and compares when the op resolves.
module tb_mdu_ctrl;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi_out, lo_out;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
`ifdef MDU_CANCEL_EN
    .cancel (cancel),
`endif
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  int          total = 0, bad = 0;
  exp_t        exp_q[$];
  int          outstanding = 0;
  int          busy_cnt = 0;
  logic [31:0] cur_hi = 32'd0, cur_lo = 32'd0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: architectural HI/LO effect of one op, 64-bit arithmetic
  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output exp_t e);
    longint      p, sx, sy, q, r;
    logic [63:0] pu;
    e.hi = m_hi; e.lo = m_lo; e.lat = 0;
    case (o)
      MDU_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT_DEF;
      end
      MDU_MULTU: begin
        pu = {32'b0, x} * {32'b0, y};
        e.hi = pu[63:32]; e.lo = pu[31:0]; e.lat = MUL_LAT_DEF;
      end
      MDU_DIV: if (y != 0) begin
        sx = longint'($signed(x)); sy = longint'($signed(y));
        q = sx / sy; r = sx % sy;
        e.lo = q[31:0]; e.hi = r[31:0]; e.lat = DIV_LAT_DEF;
      end
      MDU_DIVU: if (y != 0) begin
        e.lo = x / y; e.hi = x % y; e.lat = DIV_LAT_DEF;
      end
      MDU_MTHI: e.hi = x;
      MDU_MTLO: e.lo = x;
      default: ;
    endcase
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Called at a negedge; leaves start low and the unit idle on return
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    model(o, x, y, e);
    exp_q.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  // Count accepted starts
  always @(posedge clk) begin
    if (!reset && start) outstanding++;
    if (!reset) assert (!(busy && start)) else $error("FAIL start_while_busy");
  end

  // Monitor: count busy cycles, check HI/LO hold, resolve on busy low
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      outstanding = 0; busy_cnt = 0;
      cur_hi = 32'd0; cur_lo = 32'd0;
    end else if (busy) begin
      busy_cnt++;
      check32("hold_hi", hi_out, cur_hi);
      check32("hold_lo", lo_out, cur_lo);
    end else if (outstanding > 0) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: response with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        check32("hi", hi_out, e.hi);
        check32("lo", lo_out, e.lo);
        check_int("busy_cycles", busy_cnt, e.lat);
        cur_hi = e.hi; cur_lo = e.lo;
      end
      outstanding--;
      busy_cnt = 0;
    end
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    exp_t        e;
    int          sel;
    reset = 1'b1; start = 1'b0; op = MDU_NONE; a = '0; b = '0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check32("rst_busy", {31'b0, busy}, 32'd0);
    check32("rst_hi", hi_out, 32'd0);
    check32("rst_lo", lo_out, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(MDU_MULT,  32'hFFFFFFFD, 32'd7);
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
    issue(MDU_DIV,   32'hFFFFFFF9, 32'd2);
    issue(MDU_DIVU,  32'd7, 32'd0);
    issue(MDU_DIV,   32'h80000000, 32'hFFFFFFFF);
    issue(MDU_DIV,   32'd7, 32'hFFFFFFFE);
    op = MDU_MTHI; a = 32'h12345678;
    begin
      model(MDU_MTHI, 32'h12345678, 32'd0, e); exp_q.push_back(e);
      start = 1'b1; @(negedge clk);
      model(MDU_MTLO, 32'h9ABCDEF0, 32'd0, e); exp_q.push_back(e);
      op = MDU_MTLO; a = 32'h9ABCDEF0;
      @(negedge clk);
      start = 1'b0;
      check32("mtlo_busy", {31'b0, busy}, 32'd0);
    end
    issue(MDU_NONE, 32'h1111, 32'h2222);
    issue(4'd9, 32'h3333, 32'h4444);

    // Randomized ops including undefined codes and zero divisors
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      ro  = (sel <= 6) ? 4'(sel) : 4'($urandom_range(7, 15));
      ra  = ($urandom_range(0, 2) == 0) ? 32'($signed(-$urandom_range(0, 50))) : $urandom;
      rb  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      issue(ro, ra, rb);
    end

`ifdef MDU_CANCEL_EN
    // Cancel on the commit edge: no commit, then a fresh MULT completes
    e.hi = m_hi; e.lo = m_lo; e.lat = MUL_LAT_DEF;
    exp_q.push_back(e);
    op = MDU_MULT; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    wait_idle();
    issue(MDU_MULT, 32'd3, 32'd4);
    check32("cancel_then_mult_lo", lo_out, 32'd12);
`endif

    // Reset mid-DIV: immediate clear, no late commit after release
    issue(MDU_MTHI, 32'hDEADBEEF, 32'd0);
    issue(MDU_MTLO, 32'hCAFEF00D, 32'd0);
    model(MDU_DIV, 32'd100, 32'd3, e); exp_q.push_back(e);
    op = MDU_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check32("rstmid_busy", {31'b0, busy}, 32'd0);
    check32("rstmid_hi", hi_out, 32'd0);
    check32("rstmid_lo", lo_out, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check32("post_rst_busy", {31'b0, busy}, 32'd0);
    check32("post_rst_hi", hi_out, 32'd0);
    check32("post_rst_lo", lo_out, 32'd0);

    repeat (3) @(negedge clk);
    check_int("sb_drained", exp_q.size() + outstanding, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
